// File: rtl/rf_alu_pkg.sv
// Shared constants for the register-file ALU sequencer: opcodes, FSM encoding, default widths.
package rf_alu_pkg;

  localparam int unsigned DW_DEFAULT = 32;
  localparam int unsigned AW_DEFAULT = 5;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_NOR = 3'b110;
  localparam logic [2:0] OP_SLL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_e;

endpackage

// File: rtl/rf_alu_exec_if.sv
// Command, register-file and status signals of rf_alu_exec.
// Optional Zero/Ovf flag outputs are present when RF_ALU_FLAGS_EN is defined.
interface rf_alu_exec_if
  import rf_alu_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT,
  parameter int unsigned AW = AW_DEFAULT
) ();

  logic          Start;
  logic [2:0]    Op;
  logic [AW-1:0] Rs_Addr;
  logic [AW-1:0] Rt_Addr;
  logic [AW-1:0] Rd_Addr;
  logic [AW-1:0] R_Addr_A;
  logic [AW-1:0] R_Addr_B;
  logic [DW-1:0] R_Data_A;
  logic [DW-1:0] R_Data_B;
  logic [AW-1:0] W_Addr;
  logic [DW-1:0] W_Data;
  logic          Write_Reg;
  logic [DW-1:0] Result;
  logic          Busy;
  logic          Done;
`ifdef RF_ALU_FLAGS_EN
  logic          Zero;
  logic          Ovf;
`endif

  // Sequencer side.
  modport slave (
    input  Start, Op, Rs_Addr, Rt_Addr, Rd_Addr, R_Data_A, R_Data_B,
`ifdef RF_ALU_FLAGS_EN
    output Zero, Ovf,
`endif
    output R_Addr_A, R_Addr_B, W_Addr, W_Data, Write_Reg, Result, Busy, Done
  );

  // Command issuer / register file side.
  modport master (
    output Start, Op, Rs_Addr, Rt_Addr, Rd_Addr, R_Data_A, R_Data_B,
`ifdef RF_ALU_FLAGS_EN
    input  Zero, Ovf,
`endif
    input  R_Addr_A, R_Addr_B, W_Addr, W_Data, Write_Reg, Result, Busy, Done
  );

endinterface

// File: rtl/alu32.sv
// Combinational ALU: (a, b, op) -> (y, ovf). ovf is signed overflow for ADD/SUB, else 0.
module alu32
  import rf_alu_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [2:0]    op,
  output logic [DW-1:0] y,
  output logic          ovf
);

  localparam int unsigned SW = $clog2(DW);

  logic [DW-1:0] sum;
  logic [DW-1:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    y   = '0;
    ovf = 1'b0;
    case (op)
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_ADD: begin
        y   = sum;
        ovf = (a[DW-1] == b[DW-1]) && (sum[DW-1] != a[DW-1]);
      end
      OP_SUB: begin
        y   = diff;
        ovf = (a[DW-1] != b[DW-1]) && (diff[DW-1] != a[DW-1]);
      end
      OP_SLT: y = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_XOR: y = a ^ b;
      OP_NOR: y = ~(a | b);
      OP_SLL: y = b << a[SW-1:0];
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/rf_alu_exec.sv
// Register-to-register execution sequencer: IDLE -> READ -> EXEC -> WRITE, one op per 4 cycles.
// Define RF_ALU_FLAGS_EN to add registered Zero/Ovf outputs.
module rf_alu_exec
  import rf_alu_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT,
  parameter int unsigned AW = AW_DEFAULT
) (
  input  logic         Clk,
  input  logic         Reset,
  rf_alu_exec_if.slave bus
);

  state_e        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [AW-1:0] raddr_a_q, raddr_a_d;
  logic [AW-1:0] raddr_b_q, raddr_b_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] opa_q, opa_d;
  logic [DW-1:0] opb_q, opb_d;
  logic [DW-1:0] result_q, result_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          done_q, done_d;

  logic [DW-1:0] alu_y;
  logic          alu_ovf;

  alu32 #(
    .DW (DW)
  ) u_alu (
    .a   (opa_q),
    .b   (opb_q),
    .op  (op_q),
    .y   (alu_y),
    .ovf (alu_ovf)
  );

`ifdef RF_ALU_FLAGS_EN
  logic zero_q, zero_d;
  logic ovf_q, ovf_d;
`else
  logic unused_ovf;
  assign unused_ovf = alu_ovf;
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    raddr_a_d = raddr_a_q;
    raddr_b_d = raddr_b_q;
    rd_d      = rd_q;
    waddr_d   = waddr_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    result_d  = result_q;
    wdata_d   = wdata_q;
    done_d    = 1'b0;
`ifdef RF_ALU_FLAGS_EN
    zero_d    = zero_q;
    ovf_d     = ovf_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          op_d      = bus.Op;
          raddr_a_d = bus.Rs_Addr;
          raddr_b_d = bus.Rt_Addr;
          rd_d      = bus.Rd_Addr;
          state_d   = S_READ;
        end
      end
      S_READ: begin
        // Operands are captured here, so Rs/Rt may alias Rd safely.
        opa_d   = bus.R_Data_A;
        opb_d   = bus.R_Data_B;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        result_d = alu_y;
        wdata_d  = alu_y;
        waddr_d  = rd_q;
`ifdef RF_ALU_FLAGS_EN
        zero_d   = (alu_y == '0);
        ovf_d    = alu_ovf;
`endif
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      raddr_a_q <= '0;
      raddr_b_q <= '0;
      rd_q      <= '0;
      waddr_q   <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      result_q  <= '0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
`ifdef RF_ALU_FLAGS_EN
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      raddr_a_q <= raddr_a_d;
      raddr_b_q <= raddr_b_d;
      rd_q      <= rd_d;
      waddr_q   <= waddr_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      result_q  <= result_d;
      wdata_q   <= wdata_d;
      done_q    <= done_d;
`ifdef RF_ALU_FLAGS_EN
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
`endif
    end
  end

  // Write enable decodes from state so Reset removes it without waiting for an edge.
  assign bus.Write_Reg = (state_q == S_WRITE) && (waddr_q != '0);
  assign bus.R_Addr_A  = raddr_a_q;
  assign bus.R_Addr_B  = raddr_b_q;
  assign bus.W_Addr    = waddr_q;
  assign bus.W_Data    = wdata_q;
  assign bus.Result    = result_q;
  assign bus.Busy      = (state_q != S_IDLE);
  assign bus.Done      = done_q;
`ifdef RF_ALU_FLAGS_EN
  assign bus.Zero      = zero_q;
  assign bus.Ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_rf_alu_exec.sv
// Directed bench for rf_alu_exec with a behavioural 32x32 register file.
module tb_rf_alu_exec;
  import rf_alu_pkg::*;

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] exp;
    logic        exp_ovf;
  } vec_t;

  localparam int NV = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rf_alu_exec_if #(.DW(32), .AW(5)) bus ();

  rf_alu_exec dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  logic [31:0] rf [32] = '{default: 32'h0};
  logic        pl_en   = 1'b0;
  logic [4:0]  pl_addr = 5'd0;
  logic [31:0] pl_data = 32'h0;
  int          wr_cycles = 0;
  int          done_cnt  = 0;
  logic [4:0]  last_waddr = 5'd0;
  logic [31:0] last_wdata = 32'h0;

  int checks   = 0;
  int failures = 0;

  assign bus.R_Data_A = rf[bus.R_Addr_A];
  assign bus.R_Data_B = rf[bus.R_Addr_B];

  always @(posedge clk) begin
    if (pl_en) rf[pl_addr] <= pl_data;
    else if (bus.Write_Reg && bus.W_Addr != 5'd0) rf[bus.W_Addr] <= bus.W_Data;
    if (bus.Write_Reg) begin
      wr_cycles  <= wr_cycles + 1;
      last_waddr <= bus.W_Addr;
      last_wdata <= bus.W_Data;
    end
    if (bus.Done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge where Done is seen (or budget expires).
  task automatic start_and_wait(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, output int edges);
    bus.Start = 1'b1; bus.Op = op; bus.Rs_Addr = rs; bus.Rt_Addr = rt; bus.Rd_Addr = rd;
    edges = 0;
    do begin
      @(negedge clk);
      bus.Start = 1'b0;
      edges++;
    end while (!bus.Done && edges < 10);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int edges;
    int w0;
    w0 = wr_cycles;
    @(negedge clk);
    start_and_wait(v.op, v.rs, v.rt, v.rd, edges);
    check($sformatf("v%0d_latency", idx), 32'(edges), 32'd4);
    check($sformatf("v%0d_result", idx), bus.Result, v.exp);
    check($sformatf("v%0d_busy", idx), 32'(bus.Busy), 32'd0);
    check($sformatf("v%0d_writes", idx), 32'(wr_cycles - w0), (v.rd != 5'd0) ? 32'd1 : 32'd0);
    if (v.rd != 5'd0) begin
      check($sformatf("v%0d_waddr", idx), 32'(last_waddr), 32'(v.rd));
      check($sformatf("v%0d_wdata", idx), last_wdata, v.exp);
      check($sformatf("v%0d_rf", idx), rf[v.rd], v.exp);
    end
`ifdef RF_ALU_FLAGS_EN
    check($sformatf("v%0d_zero", idx), 32'(bus.Zero), (v.exp == 32'h0) ? 32'd1 : 32'd0);
    check($sformatf("v%0d_ovf", idx), 32'(bus.Ovf), 32'(v.exp_ovf));
`endif
    @(negedge clk);
    check($sformatf("v%0d_done_drop", idx), 32'(bus.Done), 32'd0);
  endtask

  initial begin
    vec_t vecs [NV];
    int   e1, e2, d0, w0;

    vecs[0]  = '{OP_ADD, 5'd1,  5'd2,  5'd3,  32'h0000060A, 1'b0};
    vecs[1]  = '{OP_SUB, 5'd1,  5'd4,  5'd5,  32'h00000004, 1'b0};
    vecs[2]  = '{OP_SLT, 5'd4,  5'd1,  5'd6,  32'h00000001, 1'b0};
    vecs[3]  = '{OP_SLL, 5'd1,  5'd2,  5'd7,  32'h00003038, 1'b0};
    vecs[4]  = '{OP_AND, 5'd9,  5'd10, 5'd11, 32'h00F000F0, 1'b0};
    vecs[5]  = '{OP_XOR, 5'd9,  5'd10, 5'd12, 32'hFF00FF00, 1'b0};
    vecs[6]  = '{OP_NOR, 5'd9,  5'd10, 5'd13, 32'h000F000F, 1'b0};
    vecs[7]  = '{OP_OR,  5'd1,  5'd2,  5'd0,  32'h00000607, 1'b0};
    vecs[8]  = '{OP_ADD, 5'd3,  5'd3,  5'd3,  32'h00000C14, 1'b0};
    vecs[9]  = '{OP_ADD, 5'd8,  5'd1,  5'd14, 32'h80000002, 1'b1};
    vecs[10] = '{OP_SUB, 5'd2,  5'd2,  5'd15, 32'h00000000, 1'b0};
    vecs[11] = '{OP_SLT, 5'd1,  5'd4,  5'd16, 32'h00000000, 1'b0};
    vecs[12] = '{OP_SLL, 5'd9,  5'd1,  5'd17, 32'h00030000, 1'b0};
    vecs[13] = '{OP_SUB, 5'd8,  5'd4,  5'd18, 32'h80000000, 1'b1};

    bus.Start = 1'b0; bus.Op = 3'd0;
    bus.Rs_Addr = 5'd0; bus.Rt_Addr = 5'd0; bus.Rd_Addr = 5'd0;

    #12;
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_done", 32'(bus.Done), 32'd0);
    check("rst_write_reg", 32'(bus.Write_Reg), 32'd0);
    check("rst_result", bus.Result, 32'h0);
    check("rst_waddr", 32'(bus.W_Addr), 32'd0);
    check("rst_wdata", bus.W_Data, 32'h0);
    check("rst_raddr", 32'({bus.R_Addr_A, bus.R_Addr_B}), 32'd0);
`ifdef RF_ALU_FLAGS_EN
    check("rst_flags", 32'({bus.Zero, bus.Ovf}), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    preload(5'd1, 32'h00000003);
    preload(5'd2, 32'h00000607);
    preload(5'd4, 32'hFFFFFFFF);
    preload(5'd8, 32'h7FFFFFFF);
    preload(5'd9, 32'hF0F0F0F0);
    preload(5'd10, 32'h0FF00FF0);
    preload(5'd24, 32'h00000055);

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Back-to-back: second Start lands in the Done cycle and must be accepted.
    @(negedge clk);
    start_and_wait(OP_ADD, 5'd1, 5'd2, 5'd20, e1);
    check("b2b_first_done", 32'(bus.Done), 32'd1);
    start_and_wait(OP_SUB, 5'd20, 5'd1, 5'd21, e2);
    check("b2b_latency", 32'(e2), 32'd4);
    check("b2b_rf20", rf[20], 32'h0000060A);
    check("b2b_rf21", rf[21], 32'h00000607);

    // Start held while Busy, with a different Rd, must be ignored.
    @(negedge clk);
    d0 = done_cnt;
    w0 = wr_cycles;
    bus.Start = 1'b1; bus.Op = OP_XOR; bus.Rs_Addr = 5'd1; bus.Rt_Addr = 5'd2; bus.Rd_Addr = 5'd22;
    @(negedge clk);
    bus.Rd_Addr = 5'd23;
    @(negedge clk);
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (10) @(negedge clk);
    check("busy_done_count", 32'(done_cnt - d0), 32'd1);
    check("busy_write_count", 32'(wr_cycles - w0), 32'd1);
    check("busy_rf22", rf[22], 32'h00000604);
    check("busy_rf23", rf[23], 32'h0);

    // Reset in WRITE aborts the write.
    @(negedge clk);
    d0 = done_cnt;
    bus.Start = 1'b1; bus.Op = OP_ADD; bus.Rs_Addr = 5'd1; bus.Rt_Addr = 5'd2; bus.Rd_Addr = 5'd24;
    @(negedge clk);
    bus.Start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("wr_phase_write_reg", 32'(bus.Write_Reg), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_write_reg", 32'(bus.Write_Reg), 32'd0);
    check("abort_busy", 32'(bus.Busy), 32'd0);
    check("abort_result", bus.Result, 32'h0);
    check("abort_wdata", bus.W_Data, 32'h0);
    check("abort_waddr", 32'(bus.W_Addr), 32'd0);
    check("abort_raddr", 32'({bus.R_Addr_A, bus.R_Addr_B}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_rf24", rf[24], 32'h00000055);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
